// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - SDRAM controller command/beat port shared by arbiter and controller
interface sdram_arbiter_if;
    logic [1:0]  sdr_cmd;
    logic [17:0] sdr_addr;
    logic [1:0]  sdr_ack;
    logic        sdr_rd_valid;
    logic        sdr_wr_valid;
    logic [15:0] sdr_dout;

    modport master (
        output sdr_cmd,
        output sdr_addr,
        input  sdr_ack,
        input  sdr_rd_valid,
        input  sdr_wr_valid,
        input  sdr_dout
    );

    modport slave (
        input  sdr_cmd,
        input  sdr_addr,
        output sdr_ack,
        output sdr_rd_valid,
        output sdr_wr_valid,
        output sdr_dout
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - one-burst-at-a-time SDRAM port scheduler for video refill, write-back and line fill
module sdram_arbiter #(
    parameter logic [14:0] VID_BASE    = 15'h6FF8,
    parameter int          VID_BLOCKS  = 3072,
    parameter int          CACHE_BEATS = 128,
    parameter int          VID_BEATS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vid_low,
    input  logic                  wb_req,
    input  logic                  fill_req,
    input  logic [11:0]           wb_line,
    input  logic [11:0]           fill_line,
    input  logic                  frame_start,
    sdram_arbiter_if.master       sdr,
    output logic                  cache_we,
    output logic                  cache_re,
    output logic [31:0]           vq_data,
    output logic                  vq_we,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR    = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    localparam logic [11:0] PTR_LAST   = 12'(VID_BLOCKS - 1);
    localparam logic [7:0]  CACHE_LAST = 8'(CACHE_BEATS - 1);
    localparam logic [7:0]  VID_LAST   = 8'(VID_BEATS - 1);

    logic [1:0]  state;
    logic [1:0]  op;
    logic [7:0]  cnt;
    logic [11:0] ptr;
    logic        pend;
    logic        phase;
    logic [15:0] low_half;

    logic [11:0] ptr_eff;
    logic [14:0] vid_block;
    logic [17:0] vid_addr;
    logic        in_data;
    logic        rd_beat;
    logic        wr_beat;
    logic        beat;
    logic [7:0]  beat_last;
    logic        accept;

    // A pending frame restart takes effect before this IDLE cycle's grant.
    assign ptr_eff   = pend ? 12'd0 : ptr;
    assign vid_block = VID_BASE + {3'b000, ~ptr_eff[11:2], ptr_eff[1:0]};
    assign vid_addr  = {vid_block, 3'b000};

    assign in_data   = (state == ST_DATA);
    assign rd_beat   = in_data & sdr.sdr_rd_valid;
    assign wr_beat   = in_data & sdr.sdr_wr_valid;
    assign beat      = (op == CMD_WR) ? wr_beat : rd_beat;
    assign beat_last = (op == CMD_RD32) ? VID_LAST : CACHE_LAST;
    assign accept    = (state == ST_CMD) && (sdr.sdr_ack != 2'b00);

    assign cache_we  = rd_beat & (op == CMD_RD256);
    assign cache_re  = wr_beat & (op == CMD_WR);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            op           <= CMD_NOP;
            cnt          <= 8'd0;
            sdr.sdr_cmd  <= CMD_NOP;
            sdr.sdr_addr <= 18'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Write-back outranks fill so a dirty victim leaves before its line is refilled.
                    if (vid_low) begin
                        op           <= CMD_RD32;
                        sdr.sdr_cmd  <= CMD_RD32;
                        sdr.sdr_addr <= vid_addr;
                        state        <= ST_CMD;
                    end else if (wb_req) begin
                        op           <= CMD_WR;
                        sdr.sdr_cmd  <= CMD_WR;
                        sdr.sdr_addr <= {wb_line, 6'b000000};
                        state        <= ST_CMD;
                    end else if (fill_req) begin
                        op           <= CMD_RD256;
                        sdr.sdr_cmd  <= CMD_RD256;
                        sdr.sdr_addr <= {fill_line, 6'b000000};
                        state        <= ST_CMD;
                    end else begin
                        sdr.sdr_cmd  <= CMD_NOP;
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        sdr.sdr_cmd <= CMD_NOP;
                        cnt         <= 8'd0;
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == beat_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    sdr.sdr_cmd <= CMD_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr  <= 12'd0;
            pend <= 1'b0;
        end else begin
            pend <= frame_start | (pend & (state != ST_IDLE));
            if ((state == ST_IDLE) && pend) begin
                ptr <= 12'd0;
            end else if (accept && (op == CMD_RD32)) begin
                ptr <= (ptr == PTR_LAST) ? 12'd0 : ptr + 12'd1;
            end
        end
    end

    // Video beats pair up little-end first; the odd beat completes a 32-bit word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= 1'b0;
            low_half <= 16'd0;
            vq_data  <= 32'd0;
            vq_we    <= 1'b0;
        end else begin
            vq_we <= 1'b0;
            if (accept) begin
                phase <= 1'b0;
            end else if (rd_beat && (op == CMD_RD32)) begin
                if (!phase) begin
                    low_half <= sdr.sdr_dout;
                end else begin
                    vq_data <= {sdr.sdr_dout, low_half};
                    vq_we   <= 1'b1;
                end
                phase <= ~phase;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter with a behavioural SDRAM controller
module tb_sdram_arbiter;

    localparam int VID_BLOCKS = 3072;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vid_low, wb_req, fill_req, frame_start;
    logic [11:0] wb_line, fill_line;
    logic        cache_we, cache_re, vq_we, busy;
    logic [31:0] vq_data;

    sdram_arbiter_if sif();

    sdram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .vid_low     (vid_low),
        .wb_req      (wb_req),
        .fill_req    (fill_req),
        .wb_line     (wb_line),
        .fill_line   (fill_line),
        .frame_start (frame_start),
        .sdr         (sif),
        .cache_we    (cache_we),
        .cache_re    (cache_re),
        .vq_data     (vq_data),
        .vq_we       (vq_we),
        .busy        (busy)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [19:0] exp_cmd_q[$];
    logic [31:0] exp_vq_q[$];
    int          cmds_seen = 0;
    int          vq_cnt = 0;
    int          cwe_cnt = 0;
    int          cre_cnt = 0;
    int          burst_idx = 0;
    int          ack_wait = 0;
    bit          use_gap = 1'b0;
    logic [11:0] mptr = 12'd0;
    bit          mpend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] vaddr(input logic [11:0] p);
        logic [14:0] b;
        b = 15'h6FF8 + {3'b000, ~p[11:2], p[1:0]};
        return {b, 3'b000};
    endfunction

    function automatic logic [15:0] beat_word(input int b, input int i);
        logic [15:0] w;
        w = 16'(32'h1111 * (i + 1));
        return w ^ {8'(b), 8'h00};
    endfunction

    // Monitor: pops expected commands and video words as the DUT presents them.
    initial begin
        logic [1:0]  pcmd;
        logic [17:0] paddr;
        logic [19:0] e;
        logic [31:0] ev;
        pcmd  = 2'b00;
        paddr = 18'd0;
        forever begin
            @(negedge clk);
            if (sif.sdr_cmd != 2'b00) begin
                if (pcmd == 2'b00) begin
                    cmds_seen++;
                    if (exp_cmd_q.size() == 0) begin
                        check("unexpected_cmd", {30'd0, sif.sdr_cmd}, 32'd0);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd", {30'd0, sif.sdr_cmd}, {30'd0, e[19:18]});
                        check("addr", {14'd0, sif.sdr_addr}, {14'd0, e[17:0]});
                    end
                end else begin
                    check("cmd_hold", {12'd0, sif.sdr_cmd, sif.sdr_addr}, {12'd0, pcmd, paddr});
                end
            end
            pcmd  = sif.sdr_cmd;
            paddr = sif.sdr_addr;
            if (vq_we === 1'b1) begin
                vq_cnt++;
                if (exp_vq_q.size() == 0) begin
                    check("unexpected_vq", vq_data, 32'd0);
                end else begin
                    ev = exp_vq_q.pop_front();
                    check("vq_data", vq_data, ev);
                end
            end
            if (cache_we === 1'b1) cwe_cnt++;
            if (cache_re === 1'b1) cre_cnt++;
        end
    end

    // SDRAM controller model: acknowledges each command and supplies/consumes its beats.
    initial begin
        logic [1:0]  c;
        int          nb;
        logic [15:0] lo, w;
        sif.sdr_ack      = 2'b00;
        sif.sdr_rd_valid = 1'b0;
        sif.sdr_wr_valid = 1'b0;
        sif.sdr_dout     = 16'd0;
        lo = 16'd0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && sif.sdr_cmd != 2'b00) begin
                c  = sif.sdr_cmd;
                nb = (c == 2'b10) ? 16 : 128;
                repeat (ack_wait) @(posedge clk);
                @(posedge clk); #1 sif.sdr_ack = c;
                @(posedge clk); #1 sif.sdr_ack = 2'b00;
                for (int i = 0; i < nb && rst === 1'b1; i++) begin
                    if (use_gap && i == 5) begin
                        @(posedge clk); #1;
                    end
                    if (c == 2'b01) begin
                        sif.sdr_wr_valid = 1'b1;
                    end else begin
                        w = beat_word(burst_idx, i);
                        sif.sdr_rd_valid = 1'b1;
                        sif.sdr_dout     = w;
                        if (c == 2'b10) begin
                            if (i % 2 == 0) lo = w;
                            else exp_vq_q.push_back({w, lo});
                        end
                    end
                    @(posedge clk); #1;
                    sif.sdr_rd_valid = 1'b0;
                    sif.sdr_wr_valid = 1'b0;
                end
                if (c == 2'b10) burst_idx++;
            end
        end
    end

    task automatic wait_cmds(input int target, input int budget);
        int n;
        n = 0;
        while (cmds_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("cmd_count", cmds_seen, target);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_video(input int n);
        for (int k = 0; k < n; k++) begin
            if (mpend) begin
                mptr  = 12'd0;
                mpend = 1'b0;
            end
            exp_cmd_q.push_back({2'b10, vaddr(mptr)});
            mptr = (mptr == 12'(VID_BLOCKS - 1)) ? 12'd0 : mptr + 12'd1;
        end
    endtask

    task automatic run_video(input int n, input int budget);
        int start_cmds, start_vq;
        start_cmds = cmds_seen;
        start_vq   = vq_cnt;
        push_video(n);
        @(posedge clk); #1 vid_low = 1'b1;
        wait_cmds(start_cmds + n, budget);
        @(posedge clk); #1 vid_low = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        check("vq_words", vq_cnt - start_vq, 8 * n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sdr_cmd"},  {30'd0, sif.sdr_cmd}, 32'd0);
        check({tag, "_sdr_addr"}, {14'd0, sif.sdr_addr}, 32'd0);
        check({tag, "_vq_we"},    {31'd0, vq_we}, 32'd0);
        check({tag, "_vq_data"},  vq_data, 32'd0);
        check({tag, "_cache_we"}, {31'd0, cache_we}, 32'd0);
        check({tag, "_cache_re"}, {31'd0, cache_re}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, v0;
        rst         = 1'b0;
        vid_low     = 1'b1;
        wb_req      = 1'b1;
        fill_req    = 1'b1;
        frame_start = 1'b0;
        wb_line     = 12'h123;
        fill_line   = 12'hABC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // All three requesters at once: video, then write-back, then fill.
        exp_cmd_q.push_back({2'b10, 18'h3FFA0});
        exp_cmd_q.push_back({2'b01, 18'h048C0});
        exp_cmd_q.push_back({2'b11, 18'h2AF00});
        mptr     = 12'd1;
        ack_wait = 2;
        @(posedge clk); #1 rst = 1'b1;
        wait_cmds(1, 100);
        @(posedge clk); #1 vid_low = 1'b0;
        wait_cmds(2, 300);
        check("vid_burst_words", vq_cnt, 8);
        check("vid_burst_cache_we", cwe_cnt, 0);
        @(posedge clk); #1 wb_req = 1'b0;
        wait_cmds(3, 400);
        check("wb_cache_re", cre_cnt, 128);
        check("wb_cache_we", cwe_cnt, 0);
        @(posedge clk); #1 fill_req = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        check("fill_cache_we", cwe_cnt, 128);
        check("fill_cache_re", cre_cnt, 128);
        ack_wait = 0;

        // Video burst with a stall in the beat stream.
        use_gap = 1'b1;
        run_video(1, 100);
        use_gap = 1'b0;
        check("gap_cache_we", cwe_cnt, 128);

        // frame_start during a video data phase.
        v0 = vq_cnt;
        push_video(1);
        @(posedge clk); #1 vid_low = 1'b1;
        wait_cmds(cmds_seen + 1, 100);
        @(posedge clk); #1 vid_low = 1'b0;
        repeat (6) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        mpend = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        check("frame_mid_words", vq_cnt - v0, 8);
        run_video(1, 100);

        // Walk the pointer to its last block and across the wrap.
        run_video(VID_BLOCKS - 1, (VID_BLOCKS - 1) * 30);
        check("model_wrapped", {20'd0, mptr}, 32'd0);
        run_video(1, 100);

        // Reset in the middle of a fill burst.
        fill_line = 12'h001;
        exp_cmd_q.push_back({2'b11, 18'h00040});
        @(posedge clk); #1 fill_req = 1'b1;
        wait_cmds(cmds_seen + 1, 100);
        @(posedge clk); #1 fill_req = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        c0 = cwe_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        mptr  = 12'd0;
        mpend = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_reset_cache_we", cwe_cnt, c0);
        check("post_reset_cmd", {30'd0, sif.sdr_cmd}, 32'd0);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        run_video(1, 100);

        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("vq_queue_drained", exp_vq_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Schedules the single 16-bit SDRAM controller port between three requesters: the video refill queue, cache write-back and cache line fill. It sits in the 100 MHz SDRAM clock domain between the cache controller, the video FIFO and the SDRAM controller. It issues one burst command at a time and tracks acceptance and data beats. It steers returned read data either to the cache or, packed into 32-bit words, to the video queue. It also owns the wrapping framebuffer block pointer.

## Interface

Parameters:
- VID_BASE, 15'h6FF8 — framebuffer base, in 8-word (32-byte) block units.
- VID_BLOCKS, 3072 — 32-byte blocks per frame; the pointer wraps after VID_BLOCKS-1.
- CACHE_BEATS, 128 — 16-bit beats per 256-byte cache burst.
- VID_BEATS, 16 — 16-bit beats per 32-byte video burst.

Ports:
- clk — in, 1 — single clock (SDRAM domain). This is the only clock.
- rst — in, 1 — asynchronous, active-low reset.
- vid_low — in, 1 — video queue almost empty; requests a 32-byte read.
- wb_req — in, 1 — cache requests a 256-byte write-back.
- fill_req — in, 1 — cache requests a 256-byte line fill.
- wb_line — in, 12 — write-back line address.
- fill_line — in, 12 — fill line address.
- frame_start — in, 1 — single-cycle pulse, already synchronised; restarts the video pointer.
- sdr_cmd — out, 2 — 00 nop, 01 write 256 B, 10 read 32 B, 11 read 256 B.
- sdr_addr — out, 18 — word address for sdr_cmd.
- sdr_ack — in, 2 — controller acknowledge; nonzero echoes the accepted command.
- sdr_rd_valid — in, 1 — read beat valid.
- sdr_wr_valid — in, 1 — write beat consumed.
- sdr_dout — in, 16 — read beat data.
- cache_we — out, 1 — write the current read beat into the cache.
- cache_re — out, 1 — supply the next write beat from the cache.
- vq_data — out, 32 — packed video word.
- vq_we — out, 1 — video queue write strobe.
- busy — out, 1 — state is not IDLE.

## Operation

- **States:**
  - IDLE: grant a request and load sdr_cmd, sdr_addr and op; go to CMD. With no request, stay in IDLE with sdr_cmd = 00.
  - CMD: hold sdr_cmd and sdr_addr stable until sdr_ack ≠ 00. On acceptance, drive sdr_cmd = 00, clear the beat counter and go to DATA.
  - DATA: count beats (sdr_rd_valid for reads, sdr_wr_valid for writes). When the count reaches the op's beat total, go to IDLE.
- **Priority in IDLE:** vid_low > wb_req > fill_req. Write-back must precede fill so a dirty victim is saved before its line is overwritten. Grants are non-preemptive.
- **Addresses:**
  - Write: {wb_line, 6'b0}.
  - Fill: {fill_line, 6'b0}.
  - Video: {VID_BASE + {3'b0, ~ptr[11:2], ptr[1:0]}, 3'b0}. This gives bottom-up line order; the 15-bit sum wraps modulo 2^15.
- **Video pointer ptr (12 bits):**
  - Increments when a video command is accepted.
  - Wraps from VID_BLOCKS-1 to 0.
  - frame_start sets a pending flag. The flag clears ptr to 0 on the next IDLE cycle, before arbitration. An in-flight video burst completes normally.
  - If frame_start and an acceptance-increment coincide, the pending flag still wins at the next IDLE.
- **Steering, combinational during DATA:**
  - cache_we = fill op & sdr_rd_valid.
  - cache_re = write op & sdr_wr_valid.
  - In any other state, both are 0.
- **Video packing:**
  - An even beat is latched into the low half.
  - An odd beat produces vq_data = {sdr_dout, low} and vq_we = 1 for one cycle, registered.
  - Each video burst yields 8 words. The half-word phase resets to even at every acceptance.
- Beats arriving in IDLE or CMD are ignored (protocol error; nothing is written).
- **Reset (rst = 0):** state IDLE, sdr_cmd = 00, sdr_addr = 0, ptr = 0, pending flag = 0, vq_we = 0, vq_data = 0, cache_we = 0, cache_re = 0, busy = 0. Reset mid-burst abandons the burst and no strobes are emitted afterward.

## Timing

- Request sampled in IDLE at cycle n → sdr_cmd and sdr_addr valid from n+1. busy rises at n+1.
- sdr_ack ≠ 00 in cycle m → sdr_cmd = 00 at m+1. sdr_addr holds its value.
- The final beat in cycle k → IDLE at k+1. The earliest next command is at k+2.
- vq_we is asserted the cycle after each odd beat.
- cache_we and cache_re are asserted in the same cycle as their beat valid.
- Requests arriving while busy are not latched. Requesters must hold the request level until served.

## Test plan

- **Reset:** rst low with all requests high → every output 0. After rst rises, first command 10, sdr_addr = {15'h6FF8 + 12'hFFC, 3'b0}.
- **Priority:** vid_low, wb_req and fill_req all high simultaneously → commands issued in order 10, 01, 11. The 01 command uses the wb_line address; each command starts only after the previous burst's final beat.
- **Fill:** fill_line = 12'hABC, fill_req → sdr_addr = 18'h2AF00. 128 rd_valid beats give 128 cache_we pulses; state returns to IDLE after beat 128.
- **Video packing:** beats 0x1111, 0x2222 through 16 beats → 8 vq_we pulses. The first vq_data = 32'h22221111; cache_we stays 0 throughout.
- **Wrap:** preset by running 3071 video bursts → ptr wraps to 0. The next address is {15'h6FF8 + 12'hFFC, 3'b0}.
- **frame_start mid-burst:** pulse during a video DATA phase → the burst completes with 8 vq_we. The next video address corresponds to ptr = 0.
